// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encodings and default width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full adder slice assembled from two half adders and an OR gate.
module add1 (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic carry1;
  logic carry2;

  add1 u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (carry1)
  );

  add1 u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (carry2)
  );

  assign cout = carry1 | carry2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: start/done handshake around a single full-adder slice,
// consuming one operand bit per cycle, LSB first.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;

  fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST_CNT) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // Sum bits enter at the MSB so that after WIDTH shifts the LSB has reached bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == ST_IDLE && start) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
      carry  <= bit_c;
      if (cnt != LAST_CNT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Results are published on the edge that leaves DONE, together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        sum  <= sum_sr;
        cout <= carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results and done cycles are queued when
// a start is accepted and compared when done pulses.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W:0] res;
    int         due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busyCnt = 0;
  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic exp_t makeExp(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
    exp_t e;
    e.res = {1'b0, x} + {1'b0, y};
    e.due = due;
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) checkOutput("busy_and_done", 32'd1, 32'd0);
      if (busy) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sum", 32'(sum), 32'(e.res[W-1:0]));
          checkOutput("cout", 32'(cout), 32'(e.res[W]));
          checkOutput("latency", 32'(cyc), 32'(e.due));
          checkOutput("busy_cycles", 32'(busyCnt), 32'(W));
        end
        busyCnt = 0;
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        checkOutput("missing_done", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Drives one start pulse while the DUT is idle; operands are scrambled after capture.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(makeExp(x, y, cyc + W + 2));
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkIdle(input string tag, input logic [W-1:0] expSum, input logic expCout);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ops [0:5];
    int           due;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset", '0, 1'b0);

    $display("[TB] directed adds");
    applyStimulus(8'h00, 8'h00);
    waitDrain();
    applyStimulus(8'h0F, 8'h01);
    waitDrain();
    applyStimulus(8'hA5, 8'h5A);
    waitDrain();
    applyStimulus(8'hFF, 8'h01);
    waitDrain();
    applyStimulus(8'hFF, 8'hFF);
    waitDrain();
    @(negedge clk);
    checkIdle("held", 8'hFE, 1'b1);

    $display("[TB] start ignored while running");
    @(posedge clk); #1;
    a = 8'h03;
    b = 8'h04;
    start = 1'b1;
    sb.push_back(makeExp(8'h03, 8'h04, cyc + W + 2));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'h10;
    b = 8'h10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain();

    $display("[TB] reset during run");
    @(posedge clk); #1;
    a = 8'h33;
    b = 8'h44;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    busyCnt = 0;
    @(negedge clk);
    checkIdle("abort", '0, 1'b0);
    repeat (W + 4) @(negedge clk);
    checkIdle("abort_quiet", '0, 1'b0);
    applyStimulus(8'h21, 8'h12);
    waitDrain();

    $display("[TB] start held across three adds");
    ops[0] = 8'h12; ops[1] = 8'h34;
    ops[2] = 8'hC8; ops[3] = 8'h7F;
    ops[4] = 8'h80; ops[5] = 8'h80;
    @(posedge clk); #1;
    start = 1'b1;
    due = cyc + W + 2;
    for (int i = 0; i < 3; i++) begin
      a = ops[2*i];
      b = ops[2*i+1];
      sb.push_back(makeExp(ops[2*i], ops[2*i+1], due));
      due += W + 2;
      if (i == 0) begin
        @(posedge clk); #1;
      end else begin
        repeat (W + 2) @(posedge clk);
        #1;
      end
    end
    repeat (W + 1) @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain();

    $display("[TB] random adds");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(W'($urandom), W'($urandom));
      waitDrain();
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
